// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: output modes and build defaults.
package clk_div_pkg;
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;
  localparam int   CNT_W_DEF   = 27;
  localparam int   DIV_DEF     = 99999999;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and pending divisor/mode, registered CLKO/TICK.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DIV_DEF),
  parameter logic             DEF_MODE = MODE_TOGGLE
) (
  input  logic             CLKI,
  input  logic             RST,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdiv,
  input  logic             wmode,
  output logic             pend,
  output logic             clko,
  output logic             tick
);
  logic [CNT_W-1:0] cnt, div, pdiv;
  logic             mode, pmode;
  logic             term, nmode, clko_term;

  always_comb begin
    term      = (cnt == div);
    nmode     = pend ? pmode : mode;
    clko_term = (nmode == MODE_PULSE) ? 1'b1 : ~clko;
    // a mode switch lands low so the new waveform starts from a known phase
    if (pend && (pmode != mode)) clko_term = 1'b0;
  end

  always_ff @(posedge CLKI or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      div   <= DEF_DIV;
      mode  <= DEF_MODE;
      pdiv  <= '0;
      pmode <= MODE_TOGGLE;
      pend  <= 1'b0;
      clko  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      if (sync || (!en && pend)) begin
        cnt  <= '0;
        clko <= 1'b0;
        tick <= 1'b0;
        if (pend) begin
          div  <= pdiv;
          mode <= pmode;
          pend <= 1'b0;
        end
      end else if (en) begin
        if (term) begin
          cnt  <= '0;
          tick <= 1'b1;
          clko <= clko_term;
          if (pend) begin
            div  <= pdiv;
            mode <= pmode;
            pend <= 1'b0;
          end
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
          if (mode == MODE_PULSE) clko <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
      // wr only arrives while pend is clear, so it never races an apply
      if (wr && !pend) begin
        pdiv  <= wdiv;
        pmode <= wmode;
        pend  <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers with a shared config port.
// Define CLK_DIV_SYNC_EN to add the SYNC phase-realign input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = DIV_DEF,
  parameter bit DEF_MODE = 1'b0,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLKI,
  input  logic             RST,
`ifdef CLK_DIV_SYNC_EN
  input  logic             SYNC,
`endif
  input  logic [NCH-1:0]   EN,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CH_W-1:0]  CFG_CH,
  input  logic [CNT_W-1:0] CFG_DIV,
  input  logic             CFG_MODE,
  output logic [NCH-1:0]   CLKO,
  output logic [NCH-1:0]   TICK
);
  localparam int NSLOT = 1 << CH_W;

  logic [NCH-1:0]   pend, wr;
  logic [NSLOT-1:0] pend_pad;
  logic             sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = SYNC;
`else
  assign sync = 1'b0;
`endif

  // unpopulated channel indices read as free so writes to them drop silently
  for (genvar s = 0; s < NSLOT; s++) begin : g_pad
    if (s < NCH) begin : g_live
      assign pend_pad[s] = pend[s];
    end else begin : g_void
      assign pend_pad[s] = 1'b0;
    end
  end

  assign CFG_READY = ~pend_pad[CFG_CH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr[i] = CFG_VALID && CFG_READY && (CFG_CH == CH_W'(i));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (CNT_W'(DEF_DIV)),
      .DEF_MODE(DEF_MODE)
    ) u_chan (
      .CLKI (CLKI),
      .RST  (RST),
      .en   (EN[i]),
      .sync (sync),
      .wr   (wr[i]),
      .wdiv (CFG_DIV),
      .wmode(CFG_MODE),
      .pend (pend[i]),
      .clko (CLKO[i]),
      .tick (TICK[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: three channels, reset divisor 5.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 27;

  logic          CLKI = 1'b0;
  logic          RST;
  logic [NCH-1:0] EN;
  logic          CFG_VALID, CFG_READY, CFG_MODE;
  logic [1:0]    CFG_CH;
  logic [CW-1:0] CFG_DIV;
  logic [NCH-1:0] CLKO, TICK;
  logic          sync;

  int checks = 0;
  int fails  = 0;

  clk_div_bank #(.NCH(NCH), .CNT_W(CW), .DEF_DIV(5), .DEF_MODE(1'b0)) dut (
    .CLKI     (CLKI),
    .RST      (RST),
`ifdef CLK_DIV_SYNC_EN
    .SYNC     (sync),
`endif
    .EN       (EN),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_CH   (CFG_CH),
    .CFG_DIV  (CFG_DIV),
    .CFG_MODE (CFG_MODE),
    .CLKO     (CLKO),
    .TICK     (TICK)
  );

  always #5 CLKI = ~CLKI;

  task automatic step();
    @(posedge CLKI);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int dv, input logic md);
    CFG_CH = 2'(ch); CFG_DIV = CW'(dv); CFG_MODE = md; CFG_VALID = 1'b1;
    #1;
    checks++;
    if (CFG_READY !== 1'b1) begin fails++; $display("FAIL cfg_ready_pre ch%0d: got %b want 1", ch, CFG_READY); end
    step();
    CFG_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; EN = '0; CFG_VALID = 1'b0; CFG_CH = '0; CFG_DIV = '0; CFG_MODE = 1'b0; sync = 1'b0;
    #3;
    checks++; if (CLKO !== 3'b000) begin fails++; $display("FAIL reset_clko: got %b want 000", CLKO); end
    checks++; if (TICK !== 3'b000) begin fails++; $display("FAIL reset_tick: got %b want 000", TICK); end
    checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", CFG_READY); end
    step(); step();
    RST = 1'b1;
  endtask

  task automatic test_default_div();
    logic [NCH-1:0] et, ec;
    EN = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      step();
      et = {2'b00, (k % 6) == 0};
      ec = {2'b00, ((k / 6) % 2) != 0};
      checks++; if (TICK !== et) begin fails++; $display("FAIL default_tick k=%0d: got %b want %b", k, TICK, et); end
      checks++; if (CLKO !== ec) begin fails++; $display("FAIL default_clko k=%0d: got %b want %b", k, CLKO, ec); end
    end
    EN = '0;
  endtask

  task automatic test_toggle_div3();
    logic [NCH-1:0] et, ec;
    cfg_write(0, 3, 1'b0);
    checks++; if (CFG_READY !== 1'b0) begin fails++; $display("FAIL toggle_ready_pend: got %b want 0", CFG_READY); end
    step();
    checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL toggle_ready_applied: got %b want 1", CFG_READY); end
    EN = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      step();
      et = {2'b00, (k % 4) == 0};
      ec = {2'b00, ((k / 4) % 2) != 0};
      checks++; if (TICK !== et) begin fails++; $display("FAIL toggle_tick k=%0d: got %b want %b", k, TICK, et); end
      checks++; if (CLKO !== ec) begin fails++; $display("FAIL toggle_clko k=%0d: got %b want %b", k, CLKO, ec); end
    end
    EN = '0;
  endtask

  task automatic test_pulse_ch1();
    logic [NCH-1:0] et, ec;
    logic p;
    cfg_write(1, 2, 1'b1);
    step();
    EN = 3'b011;
    for (int k = 1; k <= 12; k++) begin
      step();
      p  = (k % 3) == 0;
      et = {1'b0, p, (k % 4) == 0};
      ec = {1'b0, p, ((k / 4) % 2) != 0};
      checks++; if (TICK !== et) begin fails++; $display("FAIL pulse_tick k=%0d: got %b want %b", k, TICK, et); end
      checks++; if (CLKO !== ec) begin fails++; $display("FAIL pulse_clko k=%0d: got %b want %b", k, CLKO, ec); end
    end
    EN = '0;
  endtask

  task automatic test_pending();
    logic t, c;
    cfg_write(0, 9, 1'b0);
    step();
    EN = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        CFG_VALID = 1'b1; CFG_CH = 2'd0; CFG_DIV = CW'(1); CFG_MODE = 1'b0; #1;
        checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL pend_ready_idle: got %b want 1", CFG_READY); end
      end else if (k >= 6 && k <= 10) begin
        CFG_DIV = CW'(5); #1;
        checks++; if (CFG_READY !== 1'b0) begin fails++; $display("FAIL pend_ready_stall k=%0d: got %b want 0", k, CFG_READY); end
      end else if (k >= 11) begin
        CFG_VALID = 1'b0; #1;
        checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL pend_ready_free k=%0d: got %b want 1", k, CFG_READY); end
      end
      step();
      t = (k <= 10) ? (k == 10) : (((k - 10) % 2) == 0);
      c = (k < 10) ? 1'b0 : ((((k - 10) / 2) % 2) == 0);
      checks++; if (TICK !== {2'b00, t}) begin fails++; $display("FAIL pend_tick k=%0d: got %b want %b", k, TICK, {2'b00, t}); end
      checks++; if (CLKO[0] !== c) begin fails++; $display("FAIL pend_clko k=%0d: got %b want %b", k, CLKO[0], c); end
    end
    EN = '0;
  endtask

  task automatic test_enable_freeze();
    cfg_write(0, 9, 1'b0);
    step();
    EN = 3'b001;
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++; if (TICK[0] !== (k == 10)) begin fails++; $display("FAIL run_tick k=%0d: got %b want %b", k, TICK[0], k == 10); end
    end
    EN = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (TICK !== 3'b000) begin fails++; $display("FAIL freeze_tick k=%0d: got %b want 000", k, TICK); end
      checks++; if (CLKO[0] !== 1'b1) begin fails++; $display("FAIL freeze_clko k=%0d: got %b want 1", k, CLKO[0]); end
    end
    EN = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (TICK[0] !== (k == 5)) begin fails++; $display("FAIL resume_tick k=%0d: got %b want %b", k, TICK[0], k == 5); end
      checks++; if (CLKO[0] !== (k < 5)) begin fails++; $display("FAIL resume_clko k=%0d: got %b want %b", k, CLKO[0], k < 5); end
    end
    EN = '0;
  endtask

  task automatic test_div0();
    logic [NCH-1:0] ec;
    cfg_write(1, 0, 1'b1);
    cfg_write(2, 0, 1'b0);
    step();
    EN = 3'b110;
    for (int k = 1; k <= 6; k++) begin
      step();
      ec = {(k % 2) == 1, 1'b1, 1'b0};
      checks++; if (TICK !== 3'b110) begin fails++; $display("FAIL div0_tick k=%0d: got %b want 110", k, TICK); end
      checks++; if (CLKO !== ec) begin fails++; $display("FAIL div0_clko k=%0d: got %b want %b", k, CLKO, ec); end
    end
    EN = '0;
  endtask

  task automatic test_out_of_range();
    CFG_VALID = 1'b1; CFG_CH = 2'd3; CFG_DIV = CW'(7); CFG_MODE = 1'b1; #1;
    checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL oor_ready: got %b want 1", CFG_READY); end
    step();
    CFG_VALID = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      CFG_CH = 2'(c); #1;
      checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL oor_no_pend ch%0d: got %b want 1", c, CFG_READY); end
    end
  endtask

  task automatic test_reset_mid();
    EN = 3'b001;
    step(); step(); step();
    CFG_VALID = 1'b1; CFG_CH = 2'd0; CFG_DIV = CW'(2); CFG_MODE = 1'b0;
    step();
    CFG_VALID = 1'b0; #1;
    checks++; if (CFG_READY !== 1'b0) begin fails++; $display("FAIL rst_pend_set: got %b want 0", CFG_READY); end
    checks++; if (CLKO !== 3'b010) begin fails++; $display("FAIL rst_pre_clko: got %b want 010", CLKO); end
    RST = 1'b0; #1;
    checks++; if (CLKO !== 3'b000) begin fails++; $display("FAIL rst_async_clko: got %b want 000", CLKO); end
    checks++; if (TICK !== 3'b000) begin fails++; $display("FAIL rst_async_tick: got %b want 000", TICK); end
    checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", CFG_READY); end
    step(); step();
    RST = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (TICK !== {2'b00, k == 6}) begin fails++; $display("FAIL rst_defdiv_tick k=%0d: got %b want %b", k, TICK, {2'b00, k == 6}); end
    end
    EN = '0;
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    logic t, c;
    cfg_write(0, 3, 1'b0);
    cfg_write(1, 3, 1'b0);
    cfg_write(2, 3, 1'b0);
    step();
    EN = 3'b001;
    step(); step();
    EN = 3'b011;
    CFG_VALID = 1'b1; CFG_CH = 2'd2; CFG_DIV = CW'(3); CFG_MODE = 1'b0;
    step();
    CFG_VALID = 1'b0;
    sync = 1'b1; EN = 3'b111;
    step();
    sync = 1'b0;
    checks++; if (CLKO !== 3'b000) begin fails++; $display("FAIL sync_clko: got %b want 000", CLKO); end
    checks++; if (TICK !== 3'b000) begin fails++; $display("FAIL sync_tick: got %b want 000", TICK); end
    checks++; if (CFG_READY !== 1'b1) begin fails++; $display("FAIL sync_pend_clr: got %b want 1", CFG_READY); end
    for (int k = 1; k <= 8; k++) begin
      step();
      t = (k % 4) == 0;
      c = ((k / 4) % 2) != 0;
      checks++; if (TICK !== {3{t}}) begin fails++; $display("FAIL sync_align_tick k=%0d: got %b want %b", k, TICK, {3{t}}); end
      checks++; if (CLKO !== {3{c}}) begin fails++; $display("FAIL sync_align_clko k=%0d: got %b want %b", k, CLKO, {3{c}}); end
    end
    EN = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_default_div();
    test_toggle_div3();
    test_pulse_ch1();
    test_pending();
    test_enable_freeze();
    test_div0();
    test_out_of_range();
    test_reset_mid();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
